// File: rtl/status_flags_unit.sv
// NZCV status register with masked MSR writes and a LIFO shadow stack for exception save/restore.
// Optional `FLAG_BYPASS_EN`: N/Z/C/V expose the combinational next-state flags instead of the register.
module status_flags_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               StatusUpdate,
    input  logic               N_In,
    input  logic               Z_In,
    input  logic               C_In,
    input  logic               V_In,
    input  logic               MsrWrite,
    input  logic [3:0]         MsrData,
    input  logic [3:0]         MsrMask,
    input  logic               Push,
    input  logic               Pop,
    output logic               N,
    output logic               Z,
    output logic               C,
    output logic               V,
    output logic [DEPTH_W-1:0] Depth,
    output logic               StackErr
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

    // Flags are kept packed as {V,N,C,Z}, the same order as MsrData/MsrMask.
    logic [3:0]         flags_q;
    logic [3:0]         flags_d;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               err_q;
    logic               err_d;
    logic               do_push;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic [3:0]         stack [STACK_DEPTH];

    assign push_idx = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));

    // Push saves the pre-update flags, so the flag update below still sees flags_q.
    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q;
        do_push = 1'b0;
        if (!Stall && !(Push && Pop)) begin
            if (Pop) begin
                if (depth_q != '0) begin
                    flags_d = stack[top_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (Push) begin
                    if (depth_q < FULL) begin
                        do_push = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (MsrWrite) begin
                    flags_d = (flags_q & ~MsrMask) | (MsrData & MsrMask);
                end else if (StatusUpdate) begin
                    flags_d = {V_In, N_In, C_In, Z_In};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset; Depth alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            stack[push_idx] <= flags_q;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign {V, N, C, Z} = rst_n ? flags_d : 4'b0000;
`else
    assign {V, N, C, Z} = flags_q;
`endif

    assign Depth    = depth_q;
    assign StackErr = err_q;

endmodule

// File: tb/tb_status_flags_unit.sv
// Scoreboard bench for status_flags_unit: directed scenarios then random traffic against a queue-based model.
module tb_status_flags_unit;

    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = 4;

    logic               clk;
    logic               rst_n;
    logic               Stall;
    logic               StatusUpdate;
    logic               N_In, Z_In, C_In, V_In;
    logic               MsrWrite;
    logic [3:0]         MsrData;
    logic [3:0]         MsrMask;
    logic               Push;
    logic               Pop;
    logic               N, Z, C, V;
    logic [DEPTH_W-1:0] Depth;
    logic               StackErr;

    status_flags_unit #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .StatusUpdate(StatusUpdate),
        .N_In(N_In), .Z_In(Z_In), .C_In(C_In), .V_In(V_In),
        .MsrWrite(MsrWrite), .MsrData(MsrData), .MsrMask(MsrMask),
        .Push(Push), .Pop(Pop), .N(N), .Z(Z), .C(C), .V(V),
        .Depth(Depth), .StackErr(StackErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // din is {V,N,C,Z}, matching MsrData ordering.
    typedef struct packed {
        logic       rst_n, stall, su, msr, push, pop;
        logic [3:0] din, data, mask;
    } stim_t;

    typedef struct {
        logic [3:0] flags;
        int         depth;
        logic       err;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] m_flags = 4'b0000;
    logic [3:0] m_stack[$];
    logic       m_err = 1'b0;
    int         total = 0;
    int         bad = 0;

    function automatic stim_t mk(input logic r, st, su, msr, psh, pp,
                                 input logic [3:0] din, data, mask);
        stim_t s;
        s.rst_n = r; s.stall = st; s.su = su; s.msr = msr; s.push = psh; s.pop = pp;
        s.din = din; s.data = data; s.mask = mask;
        return s;
    endfunction

    // Flag result of one cycle according to the priority rules.
    function automatic logic [3:0] nextFlags(input logic [3:0] f, input int size,
                                             input logic [3:0] top, input stim_t s);
        if (s.stall || (s.push && s.pop)) return f;
        if (s.pop) return (size > 0) ? top : f;
        if (s.msr) return (f & ~s.mask) | (s.data & s.mask);
        if (s.su) return s.din;
        return f;
    endfunction

    task automatic applyStimulus(input stim_t s);
        exp_t       e;
        logic [3:0] nf;
        logic [3:0] top;
        @(negedge clk);
        rst_n = s.rst_n; Stall = s.stall; StatusUpdate = s.su; MsrWrite = s.msr;
        Push = s.push; Pop = s.pop; MsrData = s.data; MsrMask = s.mask;
        {V_In, N_In, C_In, Z_In} = s.din;
        top = (m_stack.size() > 0) ? m_stack[$] : 4'h0;
        if (!s.rst_n) begin
            m_flags = 4'b0000;
            m_stack.delete();
            m_err = 1'b0;
        end else if (!s.stall && !(s.push && s.pop)) begin
            nf = nextFlags(m_flags, m_stack.size(), top, s);
            if (s.pop) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_err = 1'b1;
            end else if (s.push) begin
                if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_flags);
                else m_err = 1'b1;
            end
            m_flags = nf;
        end
        e.flags = m_flags;
        e.depth = m_stack.size();
        e.err   = m_err;
`ifdef FLAG_BYPASS_EN
        top = (m_stack.size() > 0) ? m_stack[$] : 4'h0;
        e.flags = s.rst_n ? nextFlags(m_flags, m_stack.size(), top, s) : 4'b0000;
`endif
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("flags", {28'h0, V, N, C, Z}, {28'h0, e.flags});
                checkOutput("depth", {{(32-DEPTH_W){1'b0}}, Depth}, e.depth);
                checkOutput("stack_err", {31'h0, StackErr}, {31'h0, e.err});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        stim_t s;
        int    cyc;
        rst_n = 1'b0; Stall = 1'b0; StatusUpdate = 1'b0; MsrWrite = 1'b0;
        Push = 1'b0; Pop = 1'b0; MsrData = 4'h0; MsrMask = 4'h0;
        {V_In, N_In, C_In, Z_In} = 4'h0;

        $display("[TB] reset and release");
        applyStimulus(mk(0, 0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0));
        applyStimulus(mk(0, 0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0));
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0));

        $display("[TB] masked MSR writes");
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'hF));
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 4'h0, 4'hA, 4'h3));
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'hF));
        applyStimulus(mk(1, 0, 1, 1, 0, 0, 4'hF, 4'hA, 4'h3));

        $display("[TB] stack round trip");
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 4'h0, 4'h1, 4'hF));
        applyStimulus(mk(1, 0, 0, 1, 1, 0, 4'h0, 4'h2, 4'hF));
        applyStimulus(mk(1, 0, 0, 1, 1, 0, 4'h0, 4'h4, 4'hF));
        applyStimulus(mk(1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0));
        repeat (3) applyStimulus(mk(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0));

        $display("[TB] overflow then underflow");
        for (int k = 0; k < 5; k++)
            applyStimulus(mk(1, 0, 0, 1, 1, 0, 4'h0, 4'(k + 3), 4'hF));
        repeat (4) applyStimulus(mk(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0));
        applyStimulus(mk(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0));

        $display("[TB] stall and simultaneous push/pop");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 4'h0, 4'h6, 4'hF));
        applyStimulus(mk(1, 1, 1, 1, 1, 0, 4'h9, 4'hC, 4'hF));
        applyStimulus(mk(1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0));
        applyStimulus(mk(1, 0, 0, 1, 1, 0, 4'h0, 4'h5, 4'hF));
        applyStimulus(mk(1, 0, 1, 1, 1, 1, 4'hF, 4'hF, 4'hF));
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 4'h8, 4'h0, 4'h0));

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            s.rst_n = ($urandom_range(0, 79) != 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.su    = 1'($urandom);
            s.msr   = ($urandom_range(0, 3) == 0);
            s.push  = ($urandom_range(0, 9) < 3);
            s.pop   = ($urandom_range(0, 9) < 3);
            s.din   = 4'($urandom);
            s.data  = 4'($urandom);
            s.mask  = 4'($urandom);
            applyStimulus(s);
        end

        cyc = 0;
        while (expq.size() > 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (expq.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_flags_unit.md
Name: status_flags_unit

Overview:
- Architectural NZCV status register that feeds the condition-check stage.
- Latches ALU flags when an instruction's S bit is set, and accepts masked direct writes (MSR-style).
- Saves and restores flags through a small shadow stack on exception entry and return.
- Outputs N, Z, C and V drive the condition evaluator of the next instruction.

Parameters:
- STACK_DEPTH, 4, number of shadow-stack entries (1..8)
- DEPTH_W, 4, width of the Depth output; must hold values 0..STACK_DEPTH

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- Stall  input  1  pipeline freeze; blocks every state update while high
- StatusUpdate  input  1  S bit of the executing instruction
- N_In  input  1  ALU negative flag
- Z_In  input  1  ALU zero flag
- C_In  input  1  ALU carry flag
- V_In  input  1  ALU overflow flag
- MsrWrite  input  1  direct flag write request
- MsrData  input  4  direct write value, ordered {V,N,C,Z}
- MsrMask  input  4  per-bit write enable, same ordering as MsrData
- Push  input  1  exception entry: save current flags
- Pop  input  1  exception return: restore saved flags
- N  output  1  current negative flag
- Z  output  1  current zero flag
- C  output  1  current carry flag
- V  output  1  current overflow flag
- Depth  output  DEPTH_W  number of valid stack entries
- StackErr  output  1  sticky overflow/underflow error

Behaviour:
- Reset (rst_n low at a rising edge): N, Z, C, V = 0; Depth = 0; StackErr = 0; stack contents don't-care. Reset wins over every other input, including mid-sequence Push/Pop.
- All state is registered. Updates are visible one cycle after the sampling edge (latency 1).
- Stall high: flags, stack, Depth and StackErr all hold. Every other request is ignored.
- Priority each cycle with Stall low, highest first:
  1. Push and Pop together: no operation, nothing changes.
  2. Pop: if Depth > 0, flags <= top entry and Depth -= 1. If Depth = 0, flags and Depth hold and StackErr <= 1.
  3. Push: if Depth < STACK_DEPTH, top <= current flags and Depth += 1. In the same cycle, the flags still take a MsrWrite or StatusUpdate according to the ranking below. If the stack is full, nothing is stored, Depth holds and StackErr <= 1, but the flag update still applies.
  4. MsrWrite: each flag bit i with MsrMask[i] = 1 takes MsrData[i]; masked-off bits hold. MsrWrite overrides StatusUpdate in the same cycle.
  5. StatusUpdate: {V,N,C,Z} <= {V_In,N_In,C_In,Z_In}.
  6. Otherwise all state holds.
- The stack is LIFO. Entries are 4 bits; the top entry is at index Depth-1.
- Depth never wraps: saturates at STACK_DEPTH on overflow and holds at 0 on underflow.
- StackErr is sticky and clears only on reset.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: N/Z/C/V outputs become combinational next-state values, so the flags reflect same-cycle updates. Covered updates are Pop restore, MsrWrite and StatusUpdate, subject to the priority and Stall rules above. This allows an S instruction followed directly by a conditional instruction with no bubble. Depth and StackErr stay registered.
- Undefined: N/Z/C/V are pure register outputs with latency 1.

Test Plan:
- Reset behaviour: hold rst_n = 0 with StatusUpdate = 1 and N/Z/C/V_In = 1111 -> after the edge, flags = 0000 and Depth = 0. Release rst_n with the same inputs -> after the next edge, flags = 1111.
- Masked write: flags = 0000, then MsrWrite = 1, MsrData = 1010, MsrMask = 0011 -> V = 0, N = 0, C = 1, Z = 0. Repeat with StatusUpdate = 1 and inputs 1111 in the same cycle -> MsrWrite wins, same result.
- Stack round trip: STACK_DEPTH = 4.
  - Set flags 0001, Push; then 0010, Push; then 0100, Push.
  - Depth = 3. Pop -> flags 0100; Pop -> 0010; Pop -> 0001.
  - Depth = 0 and StackErr = 0 throughout.
- Overflow: five Pushes with a full stack of 4 -> Depth = 4 and StackErr = 1. Four Pops return the first four saved values in reverse order.
- Underflow: Pop at Depth = 0 -> flags unchanged, Depth = 0, StackErr = 1.
- Stall and simultaneous events:
  - Stall = 1 with StatusUpdate, MsrWrite and Push all asserted -> no change.
  - Push and Pop together at Depth = 2 -> Depth stays 2, flags unchanged.
  - With FLAG_BYPASS_EN defined: StatusUpdate with inputs 1000 -> V = 1 in the same cycle.
